sram_rd_sched: RTL and testbench

SRAM_RD_SCHED -- requirements
Module: sram_rd_sched

---
 rtl/sram_ctl_pkg.sv | 14 +
 rtl/rr_picker.sv | 29 ++
 rtl/sram_rd_sched.sv | 134 +++++++++++++
 tb/tb_sram_rd_sched.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctl_pkg.sv
// Shared constants and FSM state type for the SRAM read scheduler.
package sram_ctl_pkg;

    localparam int unsigned NUM_PORTS  = 16;
    localparam int unsigned ADDR_WIDTH = 17;
    localparam int unsigned DATA_WIDTH = 64;
    localparam int unsigned PORT_IDX_W = $clog2(NUM_PORTS);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational rotating-priority picker: first requester at or after ptr wins.
module rr_picker #(
    parameter int unsigned N = 16,
    parameter int unsigned W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] index
);

    always_comb begin
        logic         found;
        logic [W-1:0] cand;
        gnt   = '0;
        index = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = W'((32'(ptr) + i) % N);
            if (!found && req[cand]) begin
                gnt[cand] = 1'b1;
                index     = cand;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_rd_sched.sv
// Round-robin SRAM port-B read scheduler with tagged response pipeline.
// Define SRAM_RD_SCHED_PKT_LOCK_EN to keep a packet's words together (IDLE/LOCKED FSM).
module sram_rd_sched #(
    parameter int unsigned NUM_PORTS  = sram_ctl_pkg::NUM_PORTS,
    parameter int unsigned ADDR_WIDTH = sram_ctl_pkg::ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = sram_ctl_pkg::DATA_WIDTH,
    parameter int unsigned RD_LATENCY = 1,
    localparam int unsigned PortIdxW  = $clog2(NUM_PORTS)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            rd_req,
    input  logic [NUM_PORTS-1:0]            rd_last,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_PORTS-1:0]            rd_gnt,
    output logic                            enb,
    output logic [ADDR_WIDTH-1:0]           addrb,
    input  logic [DATA_WIDTH-1:0]           doutb,
    output logic                            rsp_vld,
    output logic [PortIdxW-1:0]             rsp_port,
    output logic                            rsp_last,
    output logic [DATA_WIDTH-1:0]           rsp_data,
    output logic                            busy
);

    logic [NUM_PORTS-1:0]                req_elig, pick_gnt;
    logic [PortIdxW-1:0]                 pick_idx;
    logic                                granted;
    logic [PortIdxW-1:0]                 ptr_q, ptr_d;
    logic                                enb_q, enb_d;
    logic [ADDR_WIDTH-1:0]               addrb_q, addrb_d;
    logic [RD_LATENCY:0]                 tag_vld_q, tag_vld_d;
    logic [RD_LATENCY:0][PortIdxW-1:0]   tag_port_q, tag_port_d;
    logic [RD_LATENCY:0]                 tag_last_q, tag_last_d;
    logic                                locked;
`ifdef SRAM_RD_SCHED_PKT_LOCK_EN
    sram_ctl_pkg::state_e                state_q, state_d;
    logic [PortIdxW-1:0]                 owner_q, owner_d;

    assign locked = (state_q == sram_ctl_pkg::LOCKED);
`else
    assign locked = 1'b0;
`endif

    // While a packet is locked only its owner is visible to the picker.
    always_comb begin
        req_elig = rd_req;
`ifdef SRAM_RD_SCHED_PKT_LOCK_EN
        if (locked) begin
            req_elig = rd_req & (NUM_PORTS'(1) << owner_q);
        end
`endif
    end

    rr_picker #(
        .N(NUM_PORTS),
        .W(PortIdxW)
    ) u_picker (
        .req  (req_elig),
        .ptr  (ptr_q),
        .gnt  (pick_gnt),
        .index(pick_idx)
    );

    assign rd_gnt  = rst ? '0 : pick_gnt;
    assign granted = |rd_gnt;

    always_comb begin
        ptr_d      = ptr_q;
        enb_d      = granted;
        addrb_d    = addrb_q;
        tag_vld_d  = {tag_vld_q[RD_LATENCY-1:0], granted};
        tag_port_d = {tag_port_q[RD_LATENCY-1:0], pick_idx};
        tag_last_d = {tag_last_q[RD_LATENCY-1:0], rd_last[pick_idx]};
        if (granted) begin
            addrb_d = rd_addr[32'(pick_idx) * ADDR_WIDTH +: ADDR_WIDTH];
            ptr_d   = (pick_idx == PortIdxW'(NUM_PORTS - 1)) ? '0 : pick_idx + 1'b1;
        end
`ifdef SRAM_RD_SCHED_PKT_LOCK_EN
        state_d = state_q;
        owner_d = owner_q;
        if (granted) begin
            case (state_q)
                sram_ctl_pkg::IDLE: begin
                    if (!rd_last[pick_idx]) begin
                        state_d = sram_ctl_pkg::LOCKED;
                        owner_d = pick_idx;
                    end
                end
                sram_ctl_pkg::LOCKED: begin
                    if (rd_last[pick_idx]) begin
                        state_d = sram_ctl_pkg::IDLE;
                    end
                end
            endcase
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q      <= '0;
            enb_q      <= 1'b0;
            addrb_q    <= '0;
            tag_vld_q  <= '0;
            tag_port_q <= '0;
            tag_last_q <= '0;
`ifdef SRAM_RD_SCHED_PKT_LOCK_EN
            state_q    <= sram_ctl_pkg::IDLE;
            owner_q    <= '0;
`endif
        end else begin
            ptr_q      <= ptr_d;
            enb_q      <= enb_d;
            addrb_q    <= addrb_d;
            tag_vld_q  <= tag_vld_d;
            tag_port_q <= tag_port_d;
            tag_last_q <= tag_last_d;
`ifdef SRAM_RD_SCHED_PKT_LOCK_EN
            state_q    <= state_d;
            owner_q    <= owner_d;
`endif
        end
    end

    assign enb      = enb_q;
    assign addrb    = addrb_q;
    assign rsp_vld  = tag_vld_q[RD_LATENCY];
    assign rsp_port = tag_port_q[RD_LATENCY];
    assign rsp_last = tag_last_q[RD_LATENCY];
    assign rsp_data = doutb;
    assign busy     = enb_q | (|tag_vld_q) | locked;

endmodule

// File: tb/tb_sram_rd_sched.sv
// Bench for sram_rd_sched: per-cycle queue-based reference model plus directed literal checks.
module tb_sram_rd_sched;

    localparam int NP  = 16;
    localparam int AW  = 17;
    localparam int DW  = 64;
    localparam int LAT = 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [NP-1:0]    rd_req, rd_last, rd_gnt;
    logic [NP*AW-1:0] rd_addr;
    logic             enb;
    logic [AW-1:0]    addrb;
    logic [DW-1:0]    doutb = '0;
    logic             rsp_vld;
    logic [3:0]       rsp_port;
    logic             rsp_last;
    logic [DW-1:0]    rsp_data;
    logic             busy;

    always #5 clk = ~clk;

    sram_rd_sched #(
        .NUM_PORTS (NP),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .RD_LATENCY(LAT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .rd_req  (rd_req),
        .rd_last (rd_last),
        .rd_addr (rd_addr),
        .rd_gnt  (rd_gnt),
        .enb     (enb),
        .addrb   (addrb),
        .doutb   (doutb),
        .rsp_vld (rsp_vld),
        .rsp_port(rsp_port),
        .rsp_last(rsp_last),
        .rsp_data(rsp_data),
        .busy    (busy)
    );

    function automatic logic [63:0] mem_word(input logic [AW-1:0] a);
        return {15'h05A5, a, ~a[15:0], 16'(a) ^ 16'h9E37};
    endfunction

    // One-cycle-latency SRAM.
    always @(posedge clk) begin
        if (enb) doutb <= mem_word(addrb);
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model
    typedef struct {
        int          due;
        int          port;
        logic        last;
        logic [63:0] data;
    } rsp_t;

    rsp_t          rq[$];
    int            cyc     = 0;
    int            m_ptr   = 0;
    bit            m_lock  = 0;
    int            m_owner = 0;
    logic          m_enb   = 1'b0;
    logic [AW-1:0] m_addrb = '0;

    always @(negedge clk) begin
        int            g;
        logic [AW-1:0] a;
        logic          busy_e;
        if (rst) begin
            chk("rst_gnt", 64'(rd_gnt), 64'(0));
            chk("rst_enb", 64'(enb), 64'(0));
            chk("rst_addrb", 64'(addrb), 64'(0));
            chk("rst_rsp_vld", 64'(rsp_vld), 64'(0));
            chk("rst_rsp_port", 64'(rsp_port), 64'(0));
            chk("rst_rsp_last", 64'(rsp_last), 64'(0));
            chk("rst_busy", 64'(busy), 64'(0));
            rq.delete();
            m_ptr   = 0;
            m_lock  = 0;
            m_owner = 0;
            m_enb   = 1'b0;
            m_addrb = '0;
        end else begin
            g = -1;
            if (m_lock) begin
                if (rd_req[4'(m_owner)]) g = m_owner;
            end else begin
                for (int k = 0; k < NP; k++) begin
                    if (g < 0 && rd_req[4'((m_ptr + k) % NP)]) g = (m_ptr + k) % NP;
                end
            end
            chk("gnt", 64'(rd_gnt), (g >= 0) ? (64'(1) << g) : 64'(0));
            chk("enb", 64'(enb), 64'(m_enb));
            chk("addrb", 64'(addrb), 64'(m_addrb));
            busy_e = m_enb || (rq.size() > 0) || m_lock;
            chk("busy", 64'(busy), 64'(busy_e));
            if (rq.size() > 0 && rq[0].due == cyc) begin
                chk("rsp_vld", 64'(rsp_vld), 64'(1));
                chk("rsp_port", 64'(rsp_port), 64'(rq[0].port));
                chk("rsp_last", 64'(rsp_last), 64'(rq[0].last));
                chk("rsp_data", rsp_data, rq[0].data);
                void'(rq.pop_front());
            end else begin
                chk("rsp_vld_idle", 64'(rsp_vld), 64'(0));
            end
            m_enb = (g >= 0);
            if (g >= 0) begin
                a       = rd_addr[g*AW +: AW];
                m_addrb = a;
                rq.push_back('{cyc + 1 + LAT, g, rd_last[4'(g)], mem_word(a)});
                m_ptr = (g + 1) % NP;
`ifdef SRAM_RD_SCHED_PKT_LOCK_EN
                if (!m_lock && !rd_last[4'(g)]) begin
                    m_lock  = 1;
                    m_owner = g;
                end else if (m_lock && rd_last[4'(g)]) begin
                    m_lock = 0;
                end
`endif
            end
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int p, input logic [AW-1:0] a);
        rd_addr[p*AW +: AW] = a;
    endtask

    logic [15:0] tab [12] = '{16'h0011, 16'h0000, 16'hF000, 16'h8001, 16'h0300, 16'h0000,
                              16'hFFFF, 16'h0000, 16'h0000, 16'h1248, 16'h0000, 16'h4002};

    initial begin
        int          nv;
        logic [15:0] pend;
        rst     = 1'b1;
        rd_req  = '0;
        rd_last = '0;
        rd_addr = '0;
        #1;
        chk("t0_enb", 64'(enb), 64'(0));
        chk("t0_rsp_vld", 64'(rsp_vld), 64'(0));
        chk("t0_busy", 64'(busy), 64'(0));
        repeat (2) step();
        rst = 1'b0;

        // Single request on port 3, first cycle after reset release
        set_addr(3, 17'h00100);
        rd_last = '1;
        rd_req  = 16'h0008;
        #1 chk("a_gnt", 64'(rd_gnt), 64'h0008);
        step();
        rd_req = '0;
        #1;
        chk("a_enb", 64'(enb), 64'(1));
        chk("a_addrb", 64'(addrb), 64'h00100);
        step();
        #1;
        chk("a_rsp_vld", 64'(rsp_vld), 64'(1));
        chk("a_rsp_port", 64'(rsp_port), 64'(3));
        chk("a_rsp_data", rsp_data, mem_word(17'h00100));
        repeat (2) step();

        // All ports request continuously from ptr=0
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < NP; i++) set_addr(i, AW'(32'h10000 + i * 32'h0101));
        rd_req = '1;
        nv     = 0;
        for (int i = 0; i < 32; i++) begin
            #1 chk("b_gnt_order", 64'(rd_gnt), 64'(1) << (i % 16));
            if (rsp_vld) nv++;
            step();
        end
        rd_req = '0;
        repeat (2) begin
            #1 if (rsp_vld) nv++;
            step();
        end
        chk("b_rsp_count", 64'(nv), 64'(32));

        // Wrap-around: drive ptr to 15, then ports 15 and 2
        rd_req = 16'h4000;
        #1 chk("c_gnt14", 64'(rd_gnt), 64'h4000);
        step();
        rd_req = 16'h8004;
        #1 chk("c_gnt15", 64'(rd_gnt), 64'h8000);
        step();
        rd_req = 16'h0004;
        #1 chk("c_gnt2", 64'(rd_gnt), 64'h0004);
        step();
        rd_req = '0;
        repeat (3) step();

        // Mixed traffic, requests held until granted
        rd_last = 16'hA5C3;
        pend    = '0;
        for (int i = 0; i < 24; i++) begin
            if (i < 12) pend = pend | tab[i];
            rd_req = pend;
            #1 pend = pend & ~rd_gnt;
            step();
        end
        rd_req = '0;
        repeat (4) step();

        // Reset one cycle after a grant to port 7 discards the read
        rst = 1'b1;
        step();
        rst     = 1'b0;
        rd_last = '1;
        set_addr(7, 17'h1ABCD);
        rd_req = 16'h0080;
        #1 chk("d_gnt7", 64'(rd_gnt), 64'h0080);
        step();
        rd_req = '0;
        rst    = 1'b1;
        #1;
        chk("d_enb", 64'(enb), 64'(0));
        chk("d_rsp_vld", 64'(rsp_vld), 64'(0));
        repeat (2) step();
        rst = 1'b0;
        nv  = 0;
        repeat (5) begin
            #1 if (rsp_vld) nv++;
            step();
        end
        chk("d_no_rsp", 64'(nv), 64'(0));

`ifdef SRAM_RD_SCHED_PKT_LOCK_EN
        // Port 5 four-word packet with a two-cycle gap; port 6 waits
        set_addr(5, 17'h00500);
        set_addr(6, 17'h00600);
        rd_last = 16'hFFDF;
        rd_req  = 16'h0060;
        #1 chk("f_w1", 64'(rd_gnt), 64'h0020);
        step();
        #1 chk("f_w2", 64'(rd_gnt), 64'h0020);
        step();
        rd_req = 16'h0040;
        #1 chk("f_gap1", 64'(rd_gnt), 64'h0000);
        step();
        #1 chk("f_gap2", 64'(rd_gnt), 64'h0000);
        chk("f_gap_busy", 64'(busy), 64'(1));
        step();
        rd_req = 16'h0060;
        #1 chk("f_w3", 64'(rd_gnt), 64'h0020);
        step();
        rd_last = '1;
        #1 chk("f_w4", 64'(rd_gnt), 64'h0020);
        step();
        rd_req = 16'h0040;
        #1 chk("f_p6", 64'(rd_gnt), 64'h0040);
        step();
        rd_req = '0;
        repeat (4) step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
